// File: rtl/mbe_seq_mult.sv
// rtl/mbe_seq_mult.sv - sequential radix-4 modified-Booth multiplier, one digit per cycle,
// valid/ready on both ports, signed/unsigned per transaction, pass-through tag.
module mbe_seq_mult #(
  parameter int W     = 24,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_z,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int D  = (W + 2) / 2;
  localparam int AW = 2 * W + 4;
  localparam int BW = W + 3;
  localparam int CW = $clog2(D + 1);

  if ((W % 2) != 0 || W < 4) begin : g_bad_width
    $error("mbe_seq_mult: W must be even and >= 4");
  end

  typedef enum logic [1:0] {INIT, IDLE, BUSY, HOLD} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    acc, a_sh;
  logic [BW-1:0]    b_sh;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept, last;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Handshake outputs decode the state register only, so they carry no input-to-output path.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      INIT: state_nxt = IDLE;
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == CW'(D - 1)) begin
          last      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  logic [2:0]    dig;
  logic          neg, dbl, nz;
  logic [AW-1:0] mag, addend, acc_nxt;

  // Booth digit {b[2i+1], b[2i], b[2i-1]}; negation is ~mag plus a carry-in of 1 this cycle.
  always_comb begin
    dig     = b_sh[2:0];
    neg     = dig[2] & ~(dig[1] & dig[0]);
    dbl     = (dig == 3'b011) || (dig == 3'b100);
    nz      = !((dig == 3'b000) || (dig == 3'b111));
    mag     = nz ? (dbl ? (a_sh << 1) : a_sh) : '0;
    addend  = neg ? ~mag : mag;
    acc_nxt = acc + addend + AW'(neg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      tag_q   <= '0;
      out_z   <= '0;
      out_tag <= '0;
    end else if (accept) begin
      acc   <= '0;
      a_sh  <= {{(W + 4){in_signed & in_a[W-1]}}, in_a};
      b_sh  <= {{2{in_signed & in_b[W-1]}}, in_b, 1'b0};
      cnt   <= '0;
      tag_q <= in_tag;
    end else if (state == BUSY) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      cnt  <= cnt + CW'(1);
      if (last) begin
        out_z   <= acc_nxt[2*W-1:0];
        out_tag <= tag_q;
      end
    end
  end

endmodule
